mpc_mac_pipe: RTL and testbench
===============================

Name: mpc_mac_pipe

Overview:
- Parametrised signed multiply-accumulate pipeline; next generation of the fixed-width pipelined DSP multipliers used in the MPC datapath.
- Adds configurable operand, accumulator and output widths and a configurable stage count.
- Adds a valid-tagged datapath, a running-sum accumulate mode, and a round/shift plus saturate output stage.
- Sits between the MPC matrix-row sequencer and the solver update logic; it computes dot products for the gradient and prediction terms.

Parameters:
- A_WIDTH, 21, signed width of operand a.
- B_WIDTH, 9, signed width of operand b.
- ACC_WIDTH, 48, signed accumulator width; must be ≥ A_WIDTH+B_WIDTH.
- DOUT_WIDTH, 30, signed output width.
- NUM_STAGE, 4, total latency in ce-enabled cycles; legal range 3..8.
- SHIFT, 0, arithmetic right shift applied at output, with round-half-up.
- SATURATE, 1, 1 = clamp to the DOUT range, 0 = truncate to the low DOUT_WIDTH bits.

Ports:
- clk, in, 1, clock; all logic is rising-edge.
- reset, in, 1, asynchronous active-high reset.
- ce, in, 1, clock enable; 0 freezes every register.
- in_valid, in, 1, a/b/acc_clr/acc_en carry a valid beat.
- acc_en, in, 1, 1 = add the product to the running sum; 0 = product only.
- acc_clr, in, 1, this beat starts a new sum (its product replaces the accumulator).
- a, in, A_WIDTH, signed operand.
- b, in, B_WIDTH, signed operand.
- out_valid, out, 1, dout/sat valid this cycle.
- dout, out, DOUT_WIDTH, scaled signed result.
- sat, out, 1, dout was clamped (SATURATE=1) or wrapped (SATURATE=0) on this beat.
- acc_ovf, out, 1, sticky: accumulator wrapped at ACC_WIDTH since the last acc_clr beat.

Behaviour:
- Reset: asynchronous on reset=1. All pipeline registers, the accumulator, out_valid, dout, sat and acc_ovf are cleared to 0. A reset asserted mid-operation discards all in-flight beats.
- Pipeline: stages advance only when ce=1. With ce=0, every register holds, including valid tags and outputs.
- Stage 1 registers a, b, in_valid, acc_en and acc_clr.
- Stages 2..NUM_STAGE-2 hold the full-precision signed product (A_WIDTH+B_WIDTH bits), sign-extended to ACC_WIDTH. The extra stages are retiming registers.
- Stage NUM_STAGE-1 is the accumulator, updated only for a valid beat:
  - If acc_clr=1 or acc_en=0: acc = product, and acc_ovf is cleared.
  - Otherwise: acc = acc + product, modulo 2^ACC_WIDTH. If the signed add overflows, acc_ovf is set.
  - Invalid beats leave acc unchanged.
- Stage NUM_STAGE is the output stage, computed in ACC_WIDTH+1 bits:
  - r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT.
  - If r is outside [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]:
    - SATURATE=1: clamp to the nearest bound and set sat=1.
    - SATURATE=0: dout = r[DOUT_WIDTH-1:0] and set sat=1.
  - Otherwise dout = r and sat=0.
- Latency: a valid beat accepted at ce-cycle k appears with out_valid=1 at ce-cycle k+NUM_STAGE.
- Output per beat: every valid beat produces exactly one output, which is the running sum including that beat.
- Output hold: on non-valid cycles out_valid=0, while dout and sat hold their last values.
- Back-to-back beats are accepted every ce cycle; there is no backpressure.
- acc_clr together with acc_en=1 behaves as a clear. acc_clr on an invalid beat is ignored.
- acc_ovf updates in the accumulator stage, so it is visible one cycle before the corresponding out_valid.

Test Plan:
- Product at the extremes, defaults: a=-1048576, b=-256, in_valid=1, acc_en=0 → 4 cycles later out_valid=1, dout=268435456, sat=0.
- Running sum, defaults: beats (1000,3,clr), (-200,5), (7,7), all with acc_en=1, sent back-to-back → dout sequence 3000, 2000, 2049 on consecutive cycles.
- Saturation, defaults: (-1048576,-256,clr) then (-1048576,-256) with acc_en=1 → second output dout=536870911, sat=1. With SATURATE=0 the same stimulus gives dout=-536870912, sat=1.
- Rounding, SHIFT=4: a=24, b=1 → dout=2. a=-24, b=1 → dout=-1. a=8, b=1 → dout=1.
- ce stall: one valid beat, then hold ce=0 for 5 cycles after cycle 2 → out_valid rises exactly 4 ce-high cycles after entry; registers are frozen during the stall.
- Reset mid-stream: assert reset asynchronously between clock edges with 3 beats in flight → outputs clear immediately; no out_valid pulse after release; next sum starts from 0.

Source files
------------

// File: rtl/mpc_mac_pipe.sv
// Signed multiply-accumulate pipeline for the MPC datapath.
// Stage 1 registers operands, stages 2..NUM_STAGE-2 carry the sign-extended
// product (retiming), stage NUM_STAGE-1 accumulates, stage NUM_STAGE rounds,
// shifts and saturates/wraps into the output word.
module mpc_mac_pipe #(
  parameter int A_WIDTH    = 21,
  parameter int B_WIDTH    = 9,
  parameter int ACC_WIDTH  = 48,
  parameter int DOUT_WIDTH = 30,
  parameter int NUM_STAGE  = 4,
  parameter int SHIFT      = 0,
  parameter int SATURATE   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         acc_en,
  input  logic                         acc_clr,
  input  logic signed [A_WIDTH-1:0]    a,
  input  logic signed [B_WIDTH-1:0]    b,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat,
  output logic                         acc_ovf
);

  localparam int PW  = A_WIDTH + B_WIDTH;
  localparam int NRT = NUM_STAGE - 3;
  localparam int TW  = ACC_WIDTH + 3;

  // Output range and rounding constant, all held at ACC_WIDTH+1 bits.
  localparam logic signed [ACC_WIDTH:0] DMAX =
    {{(ACC_WIDTH - DOUT_WIDTH + 2){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] DMIN = ~DMAX;
  localparam logic signed [ACC_WIDTH:0] RND =
    (SHIFT > 0) ? ({{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;

  logic signed [A_WIDTH-1:0]   s1_a;
  logic signed [B_WIDTH-1:0]   s1_b;
  logic                        s1_v, s1_en, s1_clr;
  logic signed [PW-1:0]        prod_full;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic [TW-1:0]               tag_in, tag_acc;
  logic                        p_v, p_en, p_clr;
  logic signed [ACC_WIDTH-1:0] p_prod;
  logic signed [ACC_WIDTH-1:0] acc_q, sum;
  logic                        add_ovf, acc_v;
  logic signed [ACC_WIDTH:0]   acc_x, r_c;
  logic                        hi, lo;
  logic signed [DOUT_WIDTH-1:0] dout_c;

  // Stage 1: capture operands and beat controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_v   <= 1'b0;
      s1_en  <= 1'b0;
      s1_clr <= 1'b0;
    end else if (ce) begin
      s1_a   <= a;
      s1_b   <= b;
      s1_v   <= in_valid;
      s1_en  <= acc_en;
      s1_clr <= acc_clr;
    end
  end

  assign prod_full = PW'(s1_a) * PW'(s1_b);
  assign prod_ext  = ACC_WIDTH'(prod_full);
  assign tag_in    = {s1_v, s1_en, s1_clr, prod_ext};

  // Product and its controls travel together through the retiming stages.
  if (NRT == 0) begin : gen_no_rt
    assign tag_acc = tag_in;
  end else begin : gen_rt
    logic [TW-1:0] rt_q [NRT];
    // Retiming shift register for the tagged product.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < NRT; i++) rt_q[i] <= '0;
      end else if (ce) begin
        rt_q[0] <= tag_in;
        for (int i = 1; i < NRT; i++) rt_q[i] <= rt_q[i-1];
      end
    end
    assign tag_acc = rt_q[NRT-1];
  end

  assign p_v     = tag_acc[TW-1];
  assign p_en    = tag_acc[TW-2];
  assign p_clr   = tag_acc[TW-3];
  assign p_prod  = tag_acc[ACC_WIDTH-1:0];
  assign sum     = acc_q + p_prod;
  assign add_ovf = (acc_q[ACC_WIDTH-1] == p_prod[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  // Accumulator stage: valid beats either restart or extend the running sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      acc_ovf <= 1'b0;
      acc_v   <= 1'b0;
    end else if (ce) begin
      acc_v <= p_v;
      if (p_v) begin
        if (p_clr || !p_en) begin
          acc_q   <= p_prod;
          acc_ovf <= 1'b0;
        end else begin
          acc_q   <= sum;
          acc_ovf <= acc_ovf | add_ovf;
        end
      end
    end
  end

  // Round-half-up, arithmetic shift, then range check against the output word.
  always_comb begin
    acc_x  = {acc_q[ACC_WIDTH-1], acc_q};
    r_c    = (acc_x + RND) >>> SHIFT;
    hi     = r_c > DMAX;
    lo     = r_c < DMIN;
    dout_c = r_c[DOUT_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (hi) dout_c = DMAX[DOUT_WIDTH-1:0];
      if (lo) dout_c = DMIN[DOUT_WIDTH-1:0];
    end
  end

  // Output stage: dout/sat only move on valid beats and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
    end else if (ce) begin
      out_valid <= acc_v;
      if (acc_v) begin
        dout <= dout_c;
        sat  <= hi | lo;
      end
    end
  end

endmodule

// File: tb/tb_mpc_mac_pipe.sv
// Bench for mpc_mac_pipe: four parameterisations driven by shared stimulus,
// each checked against an arithmetic running-sum model with a latency queue.
module tb_mpc_mac_pipe;

  logic clk = 1'b0;
  logic reset, ce, in_valid, acc_en, acc_clr;
  logic signed [20:0] a;
  logic signed [8:0]  b;
  logic ov [4];
  logic signed [29:0] dv [4];
  logic sv [4];
  logic ao [4];

  always #5 clk = ~clk;

  mpc_mac_pipe u0 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_en(acc_en),
    .acc_clr(acc_clr), .a(a), .b(b), .out_valid(ov[0]), .dout(dv[0]), .sat(sv[0]), .acc_ovf(ao[0]));
  mpc_mac_pipe #(.NUM_STAGE(3), .SHIFT(0), .SATURATE(0)) u1 (.clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(ov[1]), .dout(dv[1]), .sat(sv[1]), .acc_ovf(ao[1]));
  mpc_mac_pipe #(.NUM_STAGE(8), .SHIFT(4), .SATURATE(1)) u2 (.clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(ov[2]), .dout(dv[2]), .sat(sv[2]), .acc_ovf(ao[2]));
  mpc_mac_pipe #(.ACC_WIDTH(30), .NUM_STAGE(5), .SHIFT(2), .SATURATE(1)) u3 (.clk(clk),
    .reset(reset), .ce(ce), .in_valid(in_valid), .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(ov[3]), .dout(dv[3]), .sat(sv[3]), .acc_ovf(ao[3]));

  int ns_p [4] = '{4, 3, 8, 5};
  int sh_p [4] = '{0, 0, 4, 2};
  int st_p [4] = '{1, 0, 1, 1};
  int aw_p [4] = '{48, 48, 48, 30};

  typedef struct {
    int     due;
    longint d;
    logic   s;
    logic   o;
  } beat_t;

  beat_t  q [4][$];
  longint acc_m [4];
  logic   ovf_m [4];
  longint last_d [4];
  logic   last_s [4];
  logic   prev_v [4];
  int     cecnt = 0;
  int     total = 0;
  int     bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint x, input int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  // Reference output: round-half-up, shift, then clamp or wrap into 30 bits.
  task automatic out_model(input int i, input longint acc, output longint d, output logic s);
    longint rnd, r, mx, mn;
    rnd = (sh_p[i] > 0) ? (longint'(1) <<< (sh_p[i] - 1)) : 0;
    r   = (acc + rnd) >>> sh_p[i];
    mx  = (longint'(1) <<< 29) - 1;
    mn  = -mx - 1;
    s   = (r > mx) || (r < mn);
    if (!s) d = r;
    else if (st_p[i] == 0) d = wrap(r, 30);
    else d = (r > mx) ? mx : mn;
  endtask

  task automatic model_beat(input int i, input longint p, input logic en, input logic clr);
    longint nx, w, d;
    logic s;
    beat_t bt;
    if (clr || !en) begin
      acc_m[i] = p;
      ovf_m[i] = 1'b0;
    end else begin
      nx = acc_m[i] + p;
      w  = wrap(nx, aw_p[i]);
      if (w != nx) ovf_m[i] = 1'b1;
      acc_m[i] = w;
    end
    out_model(i, acc_m[i], d, s);
    bt.due = cecnt + ns_p[i] - 1;
    bt.d = d;
    bt.s = s;
    bt.o = ovf_m[i];
    q[i].push_back(bt);
  endtask

  task automatic check_dut(input int i, input logic ce_s);
    logic ev;
    if (!ce_s) begin
      chk($sformatf("d%0d_hold_valid", i), ov[i], prev_v[i]);
      chk($sformatf("d%0d_hold_dout", i), dv[i], last_d[i]);
      chk($sformatf("d%0d_hold_sat", i), sv[i], last_s[i]);
      return;
    end
    ev = (q[i].size() > 0) && (q[i][0].due == cecnt);
    chk($sformatf("d%0d_valid", i), ov[i], ev);
    if (ev) begin
      last_d[i] = q[i][0].d;
      last_s[i] = q[i][0].s;
      void'(q[i].pop_front());
    end
    chk($sformatf("d%0d_dout", i), dv[i], last_d[i]);
    chk($sformatf("d%0d_sat", i), sv[i], last_s[i]);
    prev_v[i] = ev;
    if (q[i].size() > 0 && q[i][0].due == cecnt + 1)
      chk($sformatf("d%0d_acc_ovf", i), ao[i], q[i][0].o);
  endtask

  logic ce_s, v_s, en_s, clr_s;
  logic signed [20:0] a_s;
  logic signed [8:0]  b_s;

  // Scoreboard: sample inputs at the edge, compare outputs 1 ns later.
  always @(posedge clk) begin
    ce_s = ce; v_s = in_valid; en_s = acc_en; clr_s = acc_clr; a_s = a; b_s = b;
    if (ce_s) cecnt++;
    if (!reset && ce_s && v_s)
      for (int i = 0; i < 4; i++) model_beat(i, longint'(a_s) * longint'(b_s), en_s, clr_s);
    #1;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        acc_m[i] = 0; ovf_m[i] = 1'b0;
        last_d[i] = 0; last_s[i] = 1'b0; prev_v[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) check_dut(i, ce_s);
    end
  end

  task automatic drive(input logic v, input int av, input int bv, input logic en, input logic clr);
    @(negedge clk);
    ce = 1'b1; in_valid = v; a = 21'(av); b = 9'(bv); acc_en = en; acc_clr = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic wait_valid(input int i, input int budget, input string tag, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #2;
      n++;
      if (ov[i] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, found, 1'b1);
  endtask

  task automatic sat_seq();
    drive(1'b1, -1048576, -256, 1'b1, 1'b1);
    drive(1'b1, -1048576, -256, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nce;
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid%0d", i), ov[i], 1'b0);
      chk($sformatf("rst_dout%0d", i), dv[i], 0);
      chk($sformatf("rst_ovf%0d", i), ao[i], 1'b0);
    end

    // Extreme product, product-only mode.
    drive(1'b1, -1048576, -256, 1'b0, 1'b0);
    idle(1);
    wait_valid(0, 12, "ext_timeout", n);
    chk("ext_latency", n, 3);
    chk("ext_dout", dv[0], 268435456);
    chk("ext_sat", sv[0], 1'b0);
    idle(12);

    // Running sum, back-to-back beats.
    drive(1'b1, 1000, 3, 1'b1, 1'b1);
    drive(1'b1, -200, 5, 1'b1, 1'b0);
    drive(1'b1, 7, 7, 1'b1, 1'b0);
    idle(1);
    wait_valid(0, 12, "sum_timeout", n);
    chk("sum0", dv[0], 3000);
    @(posedge clk); #2;
    chk("sum1", dv[0], 2000);
    @(posedge clk); #2;
    chk("sum2", dv[0], 2049);
    chk("sum2_valid", ov[0], 1'b1);
    idle(12);

    // Saturation (clamp) on the default build.
    sat_seq();
    wait_valid(0, 12, "satc_timeout", n);
    @(posedge clk); #2;
    chk("satc_dout", dv[0], 536870911);
    chk("satc_sat", sv[0], 1'b1);
    idle(12);
    chk("ovf_sticky", ao[3], 1'b1);

    // Same stimulus on the wrapping build.
    sat_seq();
    wait_valid(1, 12, "satw_timeout", n);
    @(posedge clk); #2;
    chk("satw_dout", dv[1], -536870912);
    chk("satw_sat", sv[1], 1'b1);
    idle(12);

    // Rounding with SHIFT=4.
    drive(1'b1, 24, 1, 1'b0, 1'b0);
    drive(1'b1, -24, 1, 1'b0, 1'b0);
    drive(1'b1, 8, 1, 1'b0, 1'b0);
    idle(1);
    wait_valid(2, 20, "rnd_timeout", n);
    chk("rnd_pos", dv[2], 2);
    @(posedge clk); #2;
    chk("rnd_neg", dv[2], -1);
    @(posedge clk); #2;
    chk("rnd_half", dv[2], 1);
    idle(12);

    // ce stall after the second cycle.
    @(negedge clk);
    ce = 1'b1; in_valid = 1'b1; a = 21'(123); b = -9'sd45; acc_en = 1'b0; acc_clr = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0;
    repeat (5) begin
      @(posedge clk); #2;
      chk("stall_valid", ov[0], 1'b0);
    end
    @(negedge clk);
    ce = 1'b1;
    nce = 2;
    wait_valid(0, 10, "stall_timeout", n);
    nce += n;
    chk("stall_ce_cycles", nce, 4);
    chk("stall_dout", dv[0], -5535);
    idle(12);

    // Asynchronous reset with three beats in flight.
    drive(1'b1, 100, 2, 1'b1, 1'b1);
    drive(1'b1, 50, 2, 1'b1, 1'b0);
    drive(1'b1, 25, 2, 1'b1, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mrst_valid%0d", i), ov[i], 1'b0);
      chk($sformatf("mrst_dout%0d", i), dv[i], 0);
      chk($sformatf("mrst_ovf%0d", i), ao[i], 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #2;
      chk("mrst_no_valid", ov[0], 1'b0);
    end
    drive(1'b1, 5, 6, 1'b1, 1'b0);
    idle(1);
    wait_valid(0, 12, "mrst_timeout", n);
    chk("mrst_fresh_sum", dv[0], 30);
    idle(12);

    // Randomised traffic with random ce stalls and operand extremes.
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      ce       = ($urandom % 100) < 85;
      in_valid = ($urandom % 100) < 75;
      acc_en   = ($urandom % 100) < 80;
      acc_clr  = ($urandom % 100) < 12;
      a        = 21'($urandom);
      b        = 9'($urandom);
      if ($urandom % 5 == 0) a = {1'b1, 20'b0};
      if ($urandom % 5 == 0) b = {1'b1, 8'b0};
    end
    idle(20);
    for (int i = 0; i < 4; i++) chk($sformatf("drain%0d", i), q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
